// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared PS/2 command/response byte codes, the one-hot state
//            encoding of the command sequencer, and a timeout helper.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Host-to-device command bytes
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  // Device-to-host response bytes
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RSP_ERR    = 8'hFC;
  localparam logic [7:0] PS2_RSP_BAT    = 8'hAA;

  // One-hot sequencer states
  typedef enum logic [7:0] {
    ST_INIT_TX  = 8'b0000_0001,
    ST_INIT_ACK = 8'b0000_0010,
    ST_INIT_BAT = 8'b0000_0100,
    ST_EN_TX    = 8'b0000_1000,
    ST_EN_ACK   = 8'b0001_0000,
    ST_IDLE     = 8'b0010_0000,
    ST_CMD_ACK  = 8'b0100_0000,
    ST_FAIL     = 8'b1000_0000
  } ps2_state_e;

  // Milliseconds to clock cycles; 64-bit so 100 MHz * 750 ms does not overflow
  function automatic longint ms_to_cycles(input longint ms, input longint hz);
    return (ms * hz) / 64'sd1000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_cmd_sequencer_if
// Purpose  : Bundles the user command port, the rx forwarding port, the
//            bring-up status and the ps2driver link of the sequencer.
//            Signal names keep the sequencer's point of view (i_ = into it).
// Revision : 1.0 - initial release
// ============================================================================
interface ps2_cmd_sequencer_if;
  // User command side
  logic [7:0] i_cmd;
  logic       i_cmd_valid;
  logic       o_cmd_ready;
  logic       o_cmd_done;
  logic       o_cmd_fail;
  // Unsolicited device bytes
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  // Bring-up status
  logic       o_init_done;
  logic       o_init_fail;
  // ps2driver link
  logic [7:0] o_drv_data;
  logic       o_drv_we;
  logic [7:0] i_drv_data;
  logic       i_drv_ready;
  logic       i_drv_error;

  // Environment view: user plus driver, drives the sequencer inputs
  modport master (
    output i_cmd, i_cmd_valid, i_drv_data, i_drv_ready, i_drv_error,
    input  o_cmd_ready, o_cmd_done, o_cmd_fail, o_rx_data, o_rx_valid,
           o_init_done, o_init_fail, o_drv_data, o_drv_we
  );

  // Sequencer view
  modport slave (
    input  i_cmd, i_cmd_valid, i_drv_data, i_drv_ready, i_drv_error,
    output o_cmd_ready, o_cmd_done, o_cmd_fail, o_rx_data, o_rx_valid,
           o_init_done, o_init_fail, o_drv_data, o_drv_we
  );
endinterface
`default_nettype wire

// File: rtl/ps2_timeout.sv
`default_nettype none
// ============================================================================
// Module   : ps2_timeout
// Purpose  : Loadable down-counter. Load wins over counting; the counter
//            parks at zero and expired_o is high while it sits there.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_timeout #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] value_i,
  output logic                  expired_o
);

  logic [WIDTH-1:0] cnt_q;

  // Reload on request, otherwise count down and hold at zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ps2_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_cmd_sequencer
// Purpose  : Host-side PS/2 command/response controller above ps2driver.
//            Runs device bring-up (FF -> FA -> AA [-> F4 -> FA]), then
//            serves one user command at a time with ACK/resend/error
//            handling, bounded retries and response timeouts, forwarding
//            unsolicited device bytes to the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_cmd_sequencer #(
  parameter int I_CLK_FRQ      = 100_000_000,
  parameter int ACK_TIMEOUT_MS = 25,
  parameter int BAT_TIMEOUT_MS = 750,
  parameter int MAX_RETRY      = 3,
  parameter int AUTO_ENABLE    = 1
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  ps2_cmd_sequencer_if.slave bus
);
  import ps2_pkg::*;

  // Timeout lengths in cycles; the timer is loaded with length-1 so that
  // expiry is acted on exactly length cycles after the load cycle.
  localparam longint ACK_CYC = ms_to_cycles(longint'(ACK_TIMEOUT_MS), longint'(I_CLK_FRQ));
  localparam longint BAT_CYC = ms_to_cycles(longint'(BAT_TIMEOUT_MS), longint'(I_CLK_FRQ));
  localparam longint MAX_CYC = (ACK_CYC > BAT_CYC) ? ACK_CYC : BAT_CYC;
  localparam int     TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int     RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0] ACK_LOAD  = TW'(ACK_CYC - 1);
  localparam logic [TW-1:0] BAT_LOAD  = TW'(BAT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  ps2_state_e    state_q, state_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    drv_data_q, drv_data_d;
  logic          drv_we_q, drv_we_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          cmd_done_q, cmd_done_d;
  logic          cmd_fail_q, cmd_fail_d;
  logic          init_done_q, init_done_d;

  logic          cmd_ready;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic          tmr_expired;

  // Response decode of the byte offered by the driver this cycle
  logic rsp_ack, rsp_resend, rsp_err, rsp_bat, rsp_other, retry_ok;
  assign rsp_ack    = bus.i_drv_ready && (bus.i_drv_data == PS2_RSP_ACK);
  assign rsp_resend = bus.i_drv_ready && (bus.i_drv_data == PS2_RSP_RESEND);
  assign rsp_err    = bus.i_drv_ready && (bus.i_drv_data == PS2_RSP_ERR);
  assign rsp_bat    = bus.i_drv_ready && (bus.i_drv_data == PS2_RSP_BAT);
  assign rsp_other  = bus.i_drv_ready && !rsp_ack && !rsp_resend && !rsp_err;
  assign retry_ok   = (retry_q < RETRY_MAX);

  ps2_timeout #(
    .WIDTH (TW)
  ) u_timeout (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .load_i    (tmr_load),
    .value_i   (tmr_value),
    .expired_o (tmr_expired)
  );

  // Next-state and registered-output logic of the sequencer
  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    drv_data_d  = drv_data_q;
    drv_we_d    = 1'b0;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    cmd_done_d  = 1'b0;
    cmd_fail_d  = 1'b0;
    init_done_d = init_done_q;
    cmd_ready   = 1'b0;
    tmr_load    = 1'b0;
    tmr_value   = ACK_LOAD;

    case (state_q)
      ST_INIT_TX: begin
        drv_data_d = PS2_CMD_RESET;
        drv_we_d   = 1'b1;
        tmr_load   = 1'b1;
        retry_d    = '0;
        state_d    = ST_INIT_ACK;
      end

      ST_INIT_ACK: begin
        if (rsp_ack) begin
          tmr_load  = 1'b1;
          tmr_value = BAT_LOAD;
          state_d   = ST_INIT_BAT;
        end else if (rsp_err) begin
          state_d = ST_FAIL;
        end else if (rsp_resend || bus.i_drv_error || tmr_expired) begin
          if (retry_ok) begin
            retry_d  = retry_q + 1'b1;
            drv_we_d = 1'b1;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end

      ST_INIT_BAT: begin
        if (rsp_bat) begin
          if (AUTO_ENABLE != 0) begin
            state_d = ST_EN_TX;
          end else begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (rsp_err || tmr_expired) begin
          state_d = ST_FAIL;
        end
      end

      ST_EN_TX: begin
        drv_data_d = PS2_CMD_ENABLE;
        drv_we_d   = 1'b1;
        tmr_load   = 1'b1;
        retry_d    = '0;
        state_d    = ST_EN_ACK;
      end

      ST_EN_ACK: begin
        if (rsp_ack) begin
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (rsp_err) begin
          state_d = ST_FAIL;
        end else if (rsp_resend || bus.i_drv_error || tmr_expired) begin
          if (retry_ok) begin
            retry_d  = retry_q + 1'b1;
            drv_we_d = 1'b1;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end

      ST_IDLE: begin
        cmd_ready = bus.i_cmd_valid;
        // Unsolicited bytes and a new command are both honoured together
        if (bus.i_drv_ready) begin
          rx_valid_d = 1'b1;
          rx_data_d  = bus.i_drv_data;
        end
        if (bus.i_cmd_valid) begin
          drv_data_d = bus.i_cmd;
          drv_we_d   = 1'b1;
          tmr_load   = 1'b1;
          retry_d    = '0;
          state_d    = ST_CMD_ACK;
        end
      end

      ST_CMD_ACK: begin
        // A non-response byte is an interleaved scan code: forward it and
        // keep waiting on the running timer
        if (rsp_other) begin
          rx_valid_d = 1'b1;
          rx_data_d  = bus.i_drv_data;
        end
        if (rsp_ack) begin
          cmd_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (rsp_err) begin
          cmd_fail_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (rsp_resend || bus.i_drv_error || tmr_expired) begin
          if (retry_ok) begin
            retry_d  = retry_q + 1'b1;
            drv_we_d = 1'b1;
            tmr_load = 1'b1;
          end else begin
            cmd_fail_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_FAIL: begin
        state_d = ST_FAIL;
      end

      default: begin
        state_d = ST_INIT_TX;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_INIT_TX;
      retry_q     <= '0;
      drv_data_q  <= 8'h00;
      drv_we_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      cmd_done_q  <= 1'b0;
      cmd_fail_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      drv_data_q  <= drv_data_d;
      drv_we_q    <= drv_we_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      cmd_done_q  <= cmd_done_d;
      cmd_fail_q  <= cmd_fail_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.o_cmd_ready = cmd_ready;
  assign bus.o_cmd_done  = cmd_done_q;
  assign bus.o_cmd_fail  = cmd_fail_q;
  assign bus.o_rx_data   = rx_data_q;
  assign bus.o_rx_valid  = rx_valid_q;
  assign bus.o_init_done = init_done_q;
  assign bus.o_init_fail = (state_q == ST_FAIL);
  assign bus.o_drv_data  = drv_data_q;
  assign bus.o_drv_we    = drv_we_q;

endmodule
`default_nettype wire
